// File: rtl/instruction_memory.sv
// instruction_memory: word-addressed instruction store with per-word valid bits,
// combinational fetch port and a one-word-per-clock loader write port.
module instruction_memory #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       PC,
    output logic [DATA_W-1:0] Instruction,
    input  logic              write_enable,
    input  logic [31:0]       write_addr,
    input  logic [DATA_W-1:0] write_data
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic              wr_go;
    logic              pc_in_range;
    logic              wa_in_range;
    logic [ADDR_W-1:0] pc_idx;
    logic [ADDR_W-1:0] wa_idx;

    assign pc_in_range = ~|PC[31:ADDR_W];
    assign wa_in_range = ~|write_addr[31:ADDR_W];
    assign pc_idx      = PC[ADDR_W-1:0];
    assign wa_idx      = write_addr[ADDR_W-1:0];

    // An X/Z strobe fails the if and therefore never writes.
    always_comb begin
        wr_go = 1'b0;
        if (write_enable == 1'b1 && wa_in_range && rst == 1'b1)
            wr_go = 1'b1;
    end

    always_comb begin
        valid_d = valid_q;
        if (wr_go)
            valid_d[wa_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            valid_q <= '0;
        else
            valid_q <= valid_d;
    end

    // Data is never reset; the valid bits mask stale contents.
    always_ff @(posedge clk) begin
        if (wr_go)
            mem_q[wa_idx] <= write_data;
    end

    assign Instruction = (rst && pc_in_range && valid_q[pc_idx]) ? mem_q[pc_idx] : '0;
endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory: directed scenarios plus randomized traffic checked
// against an array-based reference of the instruction store.
module tb_instruction_memory;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] PC = '0;
    logic [15:0] Instruction;
    logic        write_enable = 1'b0;
    logic [31:0] write_addr = '0;
    logic [15:0] write_data = '0;

    int n_checks = 0;
    int n_fails  = 0;

    logic [15:0] ref_mem [1024];
    bit          ref_vld [1024];

    instruction_memory #(.ADDR_W(10), .DATA_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .PC(PC),
        .Instruction(Instruction),
        .write_enable(write_enable),
        .write_addr(write_addr),
        .write_data(write_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_rd(input logic [31:0] a);
        if (rst !== 1'b1 || a >= 32'd1024) return 16'h0000;
        return ref_vld[a[9:0]] ? ref_mem[a[9:0]] : 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [15:0] exp);
        n_checks++;
        assert (Instruction === exp) else begin
            n_fails++;
            $error("FAIL %s: PC=%h Instruction=%h expected %h", tag, PC, Instruction, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a);
        PC = a;
        #1;
        chk(tag, ref_rd(a));
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 1024; i++) ref_vld[i] = 1'b0;
    endtask

    // One clock: drive the loader, check the pre-edge fetch, take the edge, check post-edge.
    task automatic wr(input string tag, input logic en, input logic [31:0] a, input logic [15:0] d);
        write_enable = en;
        write_addr   = a;
        write_data   = d;
        #1;
        chk({tag, "_pre"}, ref_rd(PC));
        @(posedge clk);
        if (en === 1'b1 && rst === 1'b1 && a < 32'd1024) begin
            ref_mem[a[9:0]] = d;
            ref_vld[a[9:0]] = 1'b1;
        end
        #1;
        chk({tag, "_post"}, ref_rd(PC));
        write_enable = 1'b0;
    endtask

    initial begin
        clear_ref();
        // 1: reset to empty
        #4 rst = 1'b1;
        rd("rst_pc0", 32'h000);
        chk("rst_pc0_zero", 16'h0000);
        rd("rst_pc20", 32'h020);
        rd("rst_pc3ff", 32'h3FF);
        // 2: sequential load then readback
        PC = 32'h0;
        for (int i = 0; i < 6; i++) wr("load", 1'b1, 32'h20 + i, 16'h0070 + i[15:0]);
        for (int i = 0; i < 6; i++) begin
            rd("readback", 32'h20 + i);
            chk("readback_const", 16'h0070 + i[15:0]);
        end
        // 3: write gating, including an X strobe
        PC = 32'h30;
        for (int i = 0; i < 3; i++) wr("gated", 1'b0, 32'h30, 16'hBEEF);
        wr("xstrobe", 1'bx, 32'h30, 16'hBEEF);
        rd("gated_rd", 32'h30);
        chk("gated_zero", 16'h0000);
        // 4: same-address read during write
        PC = 32'h40;
        wr("same1", 1'b1, 32'h40, 16'h1234);
        chk("same1_val", 16'h1234);
        wr("same2", 1'b1, 32'h40, 16'h5678);
        chk("same2_val", 16'h5678);
        // 5: out-of-range write dropped, aliased word untouched
        PC = 32'h420;
        wr("oor", 1'b1, 32'h0000_0420, 16'hAAAA);
        chk("oor_rd", 16'h0000);
        rd("oor_alias", 32'h020);
        chk("oor_alias_val", 16'h0070);
        rd("oor_high_pc", 32'h8000_0022);
        // 6: async reset mid-cycle
        rd("pre_rst", 32'h22);
        chk("pre_rst_val", 16'h0072);
        rst = 1'b0;
        #1;
        chk("async_drop", 16'h0000);
        clear_ref();
        wr("wr_in_rst", 1'b1, 32'h22, 16'hCAFE);
        chk("wr_in_rst_zero", 16'h0000);
        #2 rst = 1'b1;
        rd("post_rst", 32'h22);
        wr("post_rst_idle", 1'b0, 32'h22, 16'h0);
        chk("post_rst_zero", 16'h0000);
        wr("rewrite", 1'b1, 32'h22, 16'h0B0B);
        chk("rewrite_val", 16'h0B0B);
        // Randomized traffic in a small window so reads hit written words
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, 47));
            PC = ($urandom_range(0, 2) == 0) ? a : 32'($urandom_range(0, 47));
            wr("rand", ($urandom_range(0, 3) != 0), a, 16'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                #1;
                chk("rand_rst", 16'h0000);
                clear_ref();
                rst = 1'b1;
            end
            rd("rand_rd", 32'($urandom_range(0, 47)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
Word-addressed 16-bit instruction store for the fetch stage of the pipelined processor. The fetch stage reads the instruction at PC combinationally every cycle. A loader side-port writes one instruction word per clock before or while the program runs. Reset invalidates the whole store, so unloaded or cleared locations fetch as 0x0000.

Parameters:
ADDR_W, 10, number of implemented address bits; depth = 2^ADDR_W words.
DATA_W, 16, instruction word width.

Ports:
clk  input  1  system clock; all writes on rising edge.
rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
PC  input  32  read (fetch) word address.
Instruction  output  16  instruction word at PC.
write_enable  input  1  loader write strobe, active-high.
write_addr  input  32  loader word address.
write_data  input  16  loader word.

Behaviour:
- Storage: array of 2^ADDR_W words of DATA_W bits, plus one valid bit per word.
- Addressing is by word: address N is word N, with no byte scaling.
- In-range address: bits [31:ADDR_W] are all zero.
- Out-of-range address: any bit in [31:ADDR_W] is set.

Reset:
- rst low clears every valid bit immediately, without waiting for clk.
- Data contents need not be cleared.
- While rst is low:
  - Instruction = 0x0000 for any PC.
  - Writes are ignored, even if write_enable = 1.
- Release is synchronous-safe: the first write can occur on the first rising clk edge after rst goes high.

Write:
- Happens on the rising clk edge when rst = 1, write_enable = 1 and write_addr is in range.
- mem[write_addr] <= write_data and valid[write_addr] <= 1.
- Exactly one word is written per edge.
- Out-of-range write_addr: the write is silently dropped and no state changes.
- write_enable = 0, or X/Z: no write. A non-1 value is treated as 0.

Read:
- Purely combinational, zero-cycle latency: Instruction follows PC within the same cycle.
- In range and valid: Instruction = mem[PC].
- Not valid, or out of range: Instruction = 0x0000. This value is the NOP encoding.

Simultaneous read/write to the same address:
- Before the edge, Instruction shows the old value (0x0000 if invalid).
- After the edge, it shows the new value in the same cycle as the edge, because the read is combinational.
- There is no write-through bypass before the edge.

Overwrite: writing an already-valid word replaces its contents.

Reset mid-operation:
- The valid bits clear at once and Instruction drops to 0x0000 asynchronously.
- A write on the same edge that rst falls is lost.

No handshake, stall or ready signal exists.

Test Plan:
1. Reset-to-empty: rst=0 for 4 ns, then rst=1, no writes. Read PC = 0x00, 0x20 and 0x3FF -> Instruction = 0x0000 each time.
2. Sequential load/readback: rst=1, write_enable=1, one write per clock to addresses 0x20..0x25 with data 0x0070..0x0075. Then write_enable=0 and step PC 0x20..0x25 -> Instruction = 0x0070, 0x0071, 0x0072, 0x0073, 0x0074, 0x0075.
3. Write gating: write_enable=0, write_addr=0x30, write_data=0xBEEF for several clocks. Read PC=0x30 -> 0x0000.
4. Same-address read during write: PC=0x40, write 0x1234 to 0x40. Before the edge Instruction = 0x0000; after the edge Instruction = 0x1234. A second write of 0x5678 updates Instruction to 0x5678 after its edge.
5. Out-of-range: write 0xAAAA to address 0x0000_0420 (bit 10 set). Read PC=0x420 -> 0x0000, and read PC=0x020 is unchanged (0x0070 from scenario 2).
6. Async reset mid-run: after scenario 2, drive rst=0 between clock edges. Instruction at PC=0x22 drops from 0x0072 to 0x0000 with no clock edge. After rst=1, PC=0x22 still reads 0x0000 until rewritten.
